ray_scan_ctrl: RTL

RAY_SCAN_CTRL -- requirements
Module: ray_scan_ctrl

---
 rtl/ray_pkg.sv | 36 +++
 rtl/ray_color_shade.sv | 22 ++
 rtl/ray_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ray_pkg.sv
// Shared definitions for the ray scan controller: object word layout,
// coordinate widths, tracer miss code, background colour and FSM states.
package ray_pkg;

  localparam int OBJ_W     = 48;
  localparam int COLOR_MSB = 47;
  localparam int COLOR_LSB = 36;
  localparam int COLOR_W   = 12;
  localparam int RAD_MSB   = 35;
  localparam int RAD_LSB   = 28;
  localparam int CTR_MSB   = 27;
  localparam int CTR_LSB   = 0;

  localparam int ORG_X_W = 10;
  localparam int ORG_Y_W = 9;
  localparam int ORG_Z_W = 9;
  localparam int ORG_W   = ORG_X_W + ORG_Y_W + ORG_Z_W;

  localparam int DIR_X_W = 11;
  localparam int DIR_Y_W = 11;
  localparam int DIR_Z_W = 9;
  localparam int DIR_W   = DIR_X_W + DIR_Y_W + DIR_Z_W;

  localparam int T_W = 10;
  localparam logic [T_W-1:0]     T_MISS   = 10'h3FF;
  localparam logic [COLOR_W-1:0] BG_COLOR = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD,
    ST_CMP,
    ST_EMIT
  } ray_state_t;

endpackage

// File: rtl/ray_color_shade.sv
// Depth shading: darkens each 4-bit channel by t[9:6], saturating at zero.
// Only instantiated when RAY_SCAN_DEPTH_SHADE_EN is defined.
module ray_color_shade
  import ray_pkg::*;
(
  input  logic [COLOR_W-1:0] color,
  input  logic [T_W-1:0]     t,
  output logic [COLOR_W-1:0] color_out
);

  logic [T_W-1:0] dim;
  assign dim = t >> 6;

  always_comb begin
    color_out = BG_COLOR;
    for (int c = 0; c < 3; c++) begin
      if ({6'b0, color[c*4 +: 4]} > dim)
        color_out[c*4 +: 4] = 4'({6'b0, color[c*4 +: 4]} - dim);
    end
  end

endmodule

// File: rtl/ray_scan_ctrl.sv
// Raster scan controller: walks every pixel, issues each sphere object to an
// external tracer and emits the nearest hit colour. RAY_SCAN_DEPTH_SHADE_EN enables depth shading.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | obj_addr presents the current object index
// LOAD  | object memory word captured into ray_obj
// CMP   | tracer distance compared against best_t
// EMIT  | pixel offered downstream until pix_ready
module ray_scan_ctrl
  import ray_pkg::*;
#(
  parameter int              H_RES   = 640,
  parameter int              V_RES   = 480,
  parameter int              OBJ_NUM = 8,
  parameter logic signed [8:0] FOCAL = 9'sd200
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [$clog2(OBJ_NUM)-1:0] obj_addr,
  input  logic [OBJ_W-1:0]           obj_data,
  output logic [ORG_W-1:0]           ray_init,
  output logic [DIR_W-1:0]           ray_dir,
  output logic [OBJ_W-1:0]           ray_obj,
  input  logic [T_W-1:0]             t_in,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [ORG_X_W-1:0]         pix_x,
  output logic [ORG_Y_W-1:0]         pix_y,
  output logic [COLOR_W-1:0]         pix_color,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int IDX_W = $clog2(OBJ_NUM);

  ray_state_t         state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [T_W-1:0]     best_t;
  logic [COLOR_W-1:0] best_color;
  logic [COLOR_W-1:0] emit_color;
  logic [DIR_X_W-1:0] dir_x;
  logic [DIR_Y_W-1:0] dir_y;
  logic               last_obj, last_col, last_pix, hit, accept;

  assign last_obj = (idx == IDX_W'(OBJ_NUM - 1));
  assign last_col = (pix_x == ORG_X_W'(H_RES - 1));
  assign last_pix = last_col && (pix_y == ORG_Y_W'(V_RES - 1));
  assign hit      = (t_in != T_MISS) && (t_in < best_t);
  // A start coinciding with the end-of-frame pulse is dropped.
  assign accept   = start && !frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_CMP;
      ST_CMP:   state_nxt = last_obj ? ST_EMIT : ST_ISSUE;
      ST_EMIT:  if (pix_ready) state_nxt = last_pix ? ST_IDLE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      ray_obj    <= '0;
      best_t     <= T_MISS;
      best_color <= BG_COLOR;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          idx        <= '0;
          best_t     <= T_MISS;
          best_color <= BG_COLOR;
        end
        ST_LOAD: ray_obj <= obj_data;
        ST_CMP: begin
          // Strict compare keeps the lower-index object on equal distance.
          if (hit) begin
            best_t     <= t_in;
            best_color <= ray_obj[COLOR_MSB:COLOR_LSB];
          end
          idx <= last_obj ? '0 : idx + IDX_W'(1);
        end
        ST_EMIT: if (pix_ready) begin
          best_t     <= T_MISS;
          best_color <= BG_COLOR;
          if (last_pix) begin
            pix_x      <= '0;
            pix_y      <= '0;
            frame_done <= 1'b1;
          end else if (last_col) begin
            pix_x <= '0;
            pix_y <= pix_y + ORG_Y_W'(1);
          end else begin
            pix_x <= pix_x + ORG_X_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAY_SCAN_DEPTH_SHADE_EN
  ray_color_shade u_shade (
    .color     (best_color),
    .t         (best_t),
    .color_out (emit_color)
  );
`else
  assign emit_color = best_color;
`endif

  assign dir_x = {1'b0, pix_x} - DIR_X_W'(H_RES / 2);
  assign dir_y = {2'b0, pix_y} - DIR_Y_W'(V_RES / 2);

  assign obj_addr  = idx;
  assign ray_init  = '0;
  assign ray_dir   = {dir_x, dir_y, FOCAL};
  assign pix_valid = (state == ST_EMIT);
  assign pix_color = (state == ST_EMIT) ? emit_color : BG_COLOR;
  assign busy      = (state != ST_IDLE);

endmodule
